// File: rtl/slot_bus_initiator_if.sv
// ---------------------------------------------------------------------------
// slot_bus_initiator_if
//   Bundles the request-side handshake and the MSX slot-bus signals of
//   slot_bus_initiator so the initiator and its environment share one port.
//
//   Request side : i_REQ, i_REQ_IO, i_REQ_WR, i_REQ_ADDR, i_REQ_WDATA,
//                  o_READY, o_ACK, o_RDATA, o_ERR
//   Slot side    : o_SLT_IORQ, o_SLT_MERQ, o_SLT_RD, o_SLT_WR, o_SLT_A,
//                  o_SLT_WDATA, i_SLT_BUSY, i_SLT_RDATA
//
//   Signal names keep the initiator's point of view (i_ = into the
//   initiator, o_ = out of it) on both modports.
//   modport master : used by the initiator itself
//   modport slave  : used by the requester / slot model driving the i_ side
// ---------------------------------------------------------------------------
interface slot_bus_initiator_if;
   logic        i_REQ;
   logic        i_REQ_IO;
   logic        i_REQ_WR;
   logic [15:0] i_REQ_ADDR;
   logic [7:0]  i_REQ_WDATA;
   logic        o_READY;
   logic        o_ACK;
   logic [7:0]  o_RDATA;
   logic        o_ERR;
   logic        o_SLT_IORQ;
   logic        o_SLT_MERQ;
   logic        o_SLT_RD;
   logic        o_SLT_WR;
   logic [15:0] o_SLT_A;
   logic [7:0]  o_SLT_WDATA;
   logic        i_SLT_BUSY;
   logic [7:0]  i_SLT_RDATA;

   modport master (
      input  i_REQ, i_REQ_IO, i_REQ_WR, i_REQ_ADDR, i_REQ_WDATA,
      input  i_SLT_BUSY, i_SLT_RDATA,
      output o_READY, o_ACK, o_RDATA, o_ERR,
      output o_SLT_IORQ, o_SLT_MERQ, o_SLT_RD, o_SLT_WR, o_SLT_A, o_SLT_WDATA
   );

   modport slave (
      output i_REQ, i_REQ_IO, i_REQ_WR, i_REQ_ADDR, i_REQ_WDATA,
      output i_SLT_BUSY, i_SLT_RDATA,
      input  o_READY, o_ACK, o_RDATA, o_ERR,
      input  o_SLT_IORQ, o_SLT_MERQ, o_SLT_RD, o_SLT_WR, o_SLT_A, o_SLT_WDATA
   );
endinterface

// File: rtl/slot_bus_initiator.sv
// ---------------------------------------------------------------------------
// slot_bus_initiator
//   Host-side master for the MSX slot bus. Turns one accepted request into a
//   timed slot cycle: SETUP (address + IORQ/MERQ) -> STROBE (RD/WR for a
//   minimum width) -> WAIT (stretched while the responder holds busy, with a
//   timeout) -> HOLD (strobe dropped, one-cycle ACK) -> RECOVER (all
//   controls low) -> IDLE.
//
//   Ports:
//     i_CLK    system clock
//     i_RST_n  asynchronous active-low reset
//     io_bus   slot_bus_initiator_if.master (request handshake + slot bus)
// ---------------------------------------------------------------------------
module slot_bus_initiator #(
   parameter int unsigned SETUP_CYC   = 2,
   parameter int unsigned STROBE_CYC  = 20,
   parameter int unsigned HOLD_CYC    = 2,
   parameter int unsigned RECOVER_CYC = 4,
   parameter int unsigned TIMEOUT_CYC = 4095
) (
   input  logic                        i_CLK,
   input  logic                        i_RST_n,
   slot_bus_initiator_if.master        io_bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_STROBE,
      S_WAIT,
      S_HOLD,
      S_RECOVER
   } state_t;

   // Each phase loads its length minus one and counts down to zero.
   localparam logic [15:0] L_SETUP   = 16'(SETUP_CYC - 1);
   localparam logic [15:0] L_STROBE  = 16'(STROBE_CYC - 1);
   localparam logic [15:0] L_HOLD    = 16'(HOLD_CYC - 1);
   localparam logic [15:0] L_RECOVER = 16'(RECOVER_CYC - 1);
   localparam logic [15:0] L_TIMEOUT = 16'(TIMEOUT_CYC - 1);

   state_t      r_state;
   logic [15:0] r_cnt;
   logic        r_io;
   logic        r_wr;
   logic        r_err;
   logic [15:0] r_addr;
   logic [7:0]  r_wdata;
   logic [7:0]  r_rdata;

   state_t      w_state_nxt;
   logic [15:0] w_cnt_nxt;
   logic        w_accept;
   logic        w_capture;
   logic        w_timeout;
   logic        w_cnt_zero;
   logic        w_rq_on;
   logic        w_st_on;

   assign w_cnt_zero = (r_cnt == 16'd0);

   // NOTE: every always_comb output gets a default before the case so no
   // path leaves a signal unassigned, which would otherwise infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_accept    = 1'b0;
      w_capture   = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (io_bus.i_REQ) begin
               w_accept    = 1'b1;
               w_state_nxt = S_SETUP;
               w_cnt_nxt   = L_SETUP;
            end
         end
         S_SETUP: begin
            if (w_cnt_zero) begin
               w_state_nxt = S_STROBE;
               w_cnt_nxt   = L_STROBE;
            end else begin
               w_cnt_nxt = r_cnt - 16'd1;
            end
         end
         S_STROBE: begin
            // Busy is only looked at on the last minimum-width cycle.
            if (w_cnt_zero) begin
               if (!io_bus.i_SLT_BUSY) begin
                  w_capture   = 1'b1;
                  w_state_nxt = S_HOLD;
                  w_cnt_nxt   = L_HOLD;
               end else begin
                  w_state_nxt = S_WAIT;
                  w_cnt_nxt   = L_TIMEOUT;
               end
            end else begin
               w_cnt_nxt = r_cnt - 16'd1;
            end
         end
         S_WAIT: begin
            if (!io_bus.i_SLT_BUSY) begin
               w_capture   = 1'b1;
               w_state_nxt = S_HOLD;
               w_cnt_nxt   = L_HOLD;
            end else if (w_cnt_zero) begin
               w_timeout   = 1'b1;
               w_state_nxt = S_HOLD;
               w_cnt_nxt   = L_HOLD;
            end else begin
               w_cnt_nxt = r_cnt - 16'd1;
            end
         end
         S_HOLD: begin
            if (w_cnt_zero) begin
               w_state_nxt = S_RECOVER;
               w_cnt_nxt   = L_RECOVER;
            end else begin
               w_cnt_nxt = r_cnt - 16'd1;
            end
         end
         S_RECOVER: begin
            if (w_cnt_zero) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt - 16'd1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 16'd0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers
   // update together from the values present before the edge.
   always_ff @(posedge i_CLK or negedge i_RST_n) begin
      if (!i_RST_n) begin
         r_state <= S_IDLE;
         r_cnt   <= 16'd0;
         r_io    <= 1'b0;
         r_wr    <= 1'b0;
         r_err   <= 1'b0;
         r_addr  <= 16'd0;
         r_wdata <= 8'd0;
         r_rdata <= 8'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_accept) begin
            r_io    <= io_bus.i_REQ_IO;
            r_wr    <= io_bus.i_REQ_WR;
            r_addr  <= io_bus.i_REQ_ADDR;
            r_wdata <= io_bus.i_REQ_WDATA;
            r_err   <= 1'b0;
         end
         if (w_capture && !r_wr) begin
            r_rdata <= io_bus.i_SLT_RDATA;
         end
         if (w_timeout) begin
            r_err <= 1'b1;
            if (!r_wr) begin
               r_rdata <= 8'hFF;
            end
         end
      end
   end

   // Controls decode straight from the state register, so an asynchronous
   // reset drops every strobe without waiting for a clock edge.
   assign w_rq_on = (r_state == S_SETUP) || (r_state == S_STROBE) ||
                    (r_state == S_WAIT)  || (r_state == S_HOLD);
   assign w_st_on = (r_state == S_STROBE) || (r_state == S_WAIT);

   assign io_bus.o_READY     = (r_state == S_IDLE);
   // HOLD is entered with the counter at L_HOLD, so that value marks its
   // first cycle.
   assign io_bus.o_ACK       = (r_state == S_HOLD) && (r_cnt == L_HOLD);
   assign io_bus.o_ERR       = io_bus.o_ACK && r_err;
   assign io_bus.o_RDATA     = r_rdata;
   assign io_bus.o_SLT_IORQ  = w_rq_on && r_io;
   assign io_bus.o_SLT_MERQ  = w_rq_on && !r_io;
   assign io_bus.o_SLT_RD    = w_st_on && !r_wr;
   assign io_bus.o_SLT_WR    = w_st_on && r_wr;
   assign io_bus.o_SLT_A     = r_addr;
   assign io_bus.o_SLT_WDATA = r_wdata;

endmodule

// File: tb/tb_slot_bus_initiator.sv
// ---------------------------------------------------------------------------
// tb_slot_bus_initiator
//   Directed bench for slot_bus_initiator (TIMEOUT_CYC overridden to 100).
//   Cycle numbering: cycle 1 is the clock period right after the accepting
//   edge; every sample is taken 1 time unit after a rising edge.
//   With a strobe width W and no timeout the expected cycle map is:
//     IORQ/MERQ cycles 1..W+4, RD/WR cycles 3..W+2, ACK cycle W+3,
//     RECOVER cycles W+5..W+8, READY again in cycle W+9 (29 for W=20).
// ---------------------------------------------------------------------------
module tb_slot_bus_initiator;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   slot_bus_initiator_if bus ();

   slot_bus_initiator #(
      .TIMEOUT_CYC (100)
   ) dut (
      .i_CLK   (clk),
      .i_RST_n (rst_n),
      .io_bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Issues one request and follows the whole slot cycle until READY is back.
   // busy_on/busy_off are strobe-cycle numbers (1-based) where the slot model
   // raises/drops busy; 0 means never. pulse_at injects a one-cycle foreign
   // request mid-cycle; raise_at raises (and keeps) a new request to nx_addr.
   task automatic run_txn(input string tag, input logic io, input logic wr,
                          input logic [15:0] addr, input logic [7:0] wdata,
                          input logic [7:0] slot_rd, input int busy_on,
                          input int busy_off, input int exp_w,
                          input logic exp_err, input logic [7:0] exp_rdata,
                          input int pulse_at, input int raise_at,
                          input logic [15:0] nx_addr);
      int n, first_rq, rq_cnt, first_st, last_st, st_cnt;
      int ack_n, ack_cnt, ready_n, bad, wrong, unstable, stray, gap;
      logic ack_err;
      logic [7:0] ack_rdata;
      logic rq, st;
      first_rq = 0; rq_cnt = 0; first_st = 0; last_st = 0; st_cnt = 0;
      ack_n = 0; ack_cnt = 0; ready_n = 0; bad = 0; wrong = 0;
      unstable = 0; stray = 0; gap = 0; ack_err = 1'b0; ack_rdata = 8'h00;

      bus.i_REQ_IO    = io;
      bus.i_REQ_WR    = wr;
      bus.i_REQ_ADDR  = addr;
      bus.i_REQ_WDATA = wdata;
      bus.i_SLT_RDATA = slot_rd;
      bus.i_SLT_BUSY  = 1'b0;
      bus.i_REQ       = 1'b1;
      chk({tag, ".ready_before"}, 32'(bus.o_READY), 32'd1);
      @(posedge clk);
      #1;
      bus.i_REQ = 1'b0;
      n = 1;
      forever begin
         rq = bus.o_SLT_IORQ | bus.o_SLT_MERQ;
         st = bus.o_SLT_RD | bus.o_SLT_WR;
         if (bus.o_SLT_IORQ && bus.o_SLT_MERQ) bad++;
         if (bus.o_SLT_RD && bus.o_SLT_WR) bad++;
         if (st && !rq) bad++;
         if (io ? bus.o_SLT_MERQ : bus.o_SLT_IORQ) wrong++;
         if (wr ? bus.o_SLT_RD : bus.o_SLT_WR) wrong++;
         if (rq) begin
            rq_cnt++;
            if (first_rq == 0) first_rq = n;
            if (bus.o_SLT_A !== addr || bus.o_SLT_WDATA !== wdata) unstable++;
         end
         if (st) begin
            st_cnt++;
            if (first_st == 0) first_st = n;
            last_st = n;
         end
         if (rq_cnt > 0 && !rq && !st && !bus.o_ACK) gap++;
         if (bus.o_ACK) begin
            ack_cnt++;
            if (ack_n == 0) begin
               ack_n     = n;
               ack_err   = bus.o_ERR;
               ack_rdata = bus.o_RDATA;
            end
         end else if (bus.o_ERR) begin
            stray++;
         end
         if (bus.o_READY) begin
            ready_n = n;
            break;
         end
         if (n >= 400) begin
            chk({tag, ".cycle_budget"}, 32'(n), 32'd0);
            break;
         end
         bus.i_SLT_BUSY = (busy_on != 0) && (st_cnt >= busy_on) &&
                          ((busy_off == 0) || (st_cnt < busy_off));
         if (n == pulse_at) begin
            bus.i_REQ_ADDR = 16'hBEEF;
            bus.i_REQ      = 1'b1;
         end else if (pulse_at != 0 && n == pulse_at + 1) begin
            bus.i_REQ_ADDR = addr;
            bus.i_REQ      = 1'b0;
         end
         if (n == raise_at) begin
            bus.i_REQ_ADDR = nx_addr;
            bus.i_REQ      = 1'b1;
         end
         @(posedge clk);
         #1;
         n++;
      end
      bus.i_SLT_BUSY = 1'b0;

      chk({tag, ".rq_first"},  32'(first_rq),  32'd1);
      chk({tag, ".rq_len"},    32'(rq_cnt),    32'(exp_w + 4));
      chk({tag, ".st_first"},  32'(first_st),  32'd3);
      chk({tag, ".st_last"},   32'(last_st),   32'(exp_w + 2));
      chk({tag, ".st_len"},    32'(st_cnt),    32'(exp_w));
      chk({tag, ".ack_cycle"}, 32'(ack_n),     32'(exp_w + 3));
      chk({tag, ".ack_count"}, 32'(ack_cnt),   32'd1);
      chk({tag, ".ack_err"},   32'(ack_err),   32'(exp_err));
      chk({tag, ".rdata"},     32'(ack_rdata), 32'(exp_rdata));
      chk({tag, ".ready_cyc"}, 32'(ready_n),   32'(exp_w + 9));
      chk({tag, ".exclusive"}, 32'(bad),       32'd0);
      chk({tag, ".rq_st_kind"},32'(wrong),     32'd0);
      chk({tag, ".a_wd_hold"}, 32'(unstable),  32'd0);
      chk({tag, ".err_stray"}, 32'(stray),     32'd0);
      chk({tag, ".idle_gap4"}, 32'(gap >= 4),  32'd1);
   endtask

   initial begin
      n_checks        = 0;
      n_fail          = 0;
      rst_n           = 1'b0;
      bus.i_REQ       = 1'b0;
      bus.i_REQ_IO    = 1'b0;
      bus.i_REQ_WR    = 1'b0;
      bus.i_REQ_ADDR  = 16'h0000;
      bus.i_REQ_WDATA = 8'h00;
      bus.i_SLT_BUSY  = 1'b0;
      bus.i_SLT_RDATA = 8'h00;

      // Reset state
      #2;
      chk("rst.ready", 32'(bus.o_READY), 32'd1);
      chk("rst.ctrl",  32'({bus.o_ACK, bus.o_ERR, bus.o_SLT_IORQ, bus.o_SLT_MERQ,
                            bus.o_SLT_RD, bus.o_SLT_WR}), 32'd0);
      chk("rst.addr",  32'(bus.o_SLT_A), 32'd0);
      chk("rst.wdata", 32'(bus.o_SLT_WDATA), 32'd0);
      chk("rst.rdata", 32'(bus.o_RDATA), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: I/O write, no busy
      run_txn("t1_io_wr", 1'b1, 1'b1, 16'h0000, 8'h15, 8'h00, 0, 0, 20, 1'b0,
              8'h00, 0, 0, 16'h0000);
      // 2: I/O read, slot returns 0x5A
      run_txn("t2_io_rd", 1'b1, 1'b0, 16'h0001, 8'h00, 8'h5A, 0, 0, 20, 1'b0,
              8'h5A, 0, 0, 16'h0000);
      // 3: busy stretch, write leaves read data unchanged
      run_txn("t3_busy", 1'b1, 1'b1, 16'h00A0, 8'hC3, 8'h11, 2, 60, 60, 1'b0,
              8'h5A, 0, 0, 16'h0000);
      // 4: memory read, busy stuck -> 20 + 100 strobe cycles, error, 0xFF
      run_txn("t4_tmo", 1'b0, 1'b1 ^ 1'b1, 16'h4000, 8'h00, 8'h33, 1, 0, 120,
              1'b1, 8'hFF, 0, 0, 16'h0000);
      // 5: mid-cycle pulse ignored, held request accepted right after RECOVER
      run_txn("t5_b2b_a", 1'b1, 1'b1, 16'h0010, 8'h77, 8'h00, 0, 0, 20, 1'b0,
              8'hFF, 10, 26, 16'h0011);
      run_txn("t5_b2b_b", 1'b1, 1'b1, 16'h0011, 8'h77, 8'h00, 0, 0, 20, 1'b0,
              8'hFF, 0, 0, 16'h0000);

      // 6: reset during STROBE of a write
      bus.i_REQ_IO    = 1'b1;
      bus.i_REQ_WR    = 1'b1;
      bus.i_REQ_ADDR  = 16'h1234;
      bus.i_REQ_WDATA = 8'hAB;
      bus.i_REQ       = 1'b1;
      @(posedge clk);
      #1;
      bus.i_REQ = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      chk("t6.wr_before", 32'(bus.o_SLT_WR), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6.wr_async",    32'(bus.o_SLT_WR),    32'd0);
      chk("t6.iorq_async",  32'(bus.o_SLT_IORQ),  32'd0);
      chk("t6.addr_async",  32'(bus.o_SLT_A),     32'd0);
      chk("t6.wdata_async", 32'(bus.o_SLT_WDATA), 32'd0);
      chk("t6.ready_async", 32'(bus.o_READY),     32'd1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("t6.no_ack", 32'(bus.o_ACK), 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("t6.ready_after", 32'(bus.o_READY), 32'd1);
      run_txn("t6_rd", 1'b1, 1'b0, 16'h0002, 8'h00, 8'h9C, 0, 0, 20, 1'b0,
              8'h9C, 0, 0, 16'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
